// File: rtl/handshake_constant_sink.sv
// handshake_constant_sink
// Consumes words on a valid/ready data channel and compares each accepted
// word against the compile-time constant EXPECTED. Every accepted word
// yields one dataless control token through a 2-entry elastic buffer.
// ins_ready and ctrl_valid are registered decodes of the occupancy state,
// so neither handshake direction has a combinational path through the block.
//
// Optional feature macro: HANDSHAKE_CONSTANT_SINK_STATS_EN
//   defined   -> saturating 16-bit token_count / mismatch_count registers
//   undefined -> both counter outputs tie to 16'h0000
module handshake_constant_sink #(
    parameter int unsigned             DATA_WIDTH = 36,
    parameter logic [DATA_WIDTH-1:0]   EXPECTED   = DATA_WIDTH'(36'h6DC59362C)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic                  mismatch,
    output logic [15:0]           mismatch_count,
    output logic [15:0]           token_count
);

    localparam int unsigned CNT_W = 16;

    // Token occupancy states
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_ins_ready;
    logic       r_ctrl_valid;
    logic       r_mismatch;
    logic       w_acc;
    logic       w_emit;
    logic       w_word_bad;

    // Handshake qualifiers built only from registered flow-control flags
    assign w_acc      = ins_valid & r_ins_ready;
    assign w_emit     = r_ctrl_valid & ctrl_ready;
    assign w_word_bad = w_acc & (ins != EXPECTED);

    // Next occupancy: cnt + acc - emit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_acc && !w_emit) begin
                    w_state_nxt = S_FULL;
                end else if (!w_acc && w_emit) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_emit) begin
                    w_state_nxt = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Occupancy register with registered decodes of the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_EMPTY;
            r_ins_ready  <= 1'b1;
            r_ctrl_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ins_ready  <= (w_state_nxt != S_FULL);
            r_ctrl_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    // Sticky mismatch flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mismatch <= 1'b0;
        end else if (w_word_bad) begin
            r_mismatch <= 1'b1;
        end
    end

    assign ins_ready  = r_ins_ready;
    assign ctrl_valid = r_ctrl_valid;
    assign mismatch   = r_mismatch;

`ifdef HANDSHAKE_CONSTANT_SINK_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_token_count;
    logic [CNT_W-1:0] r_mismatch_count;

    // Saturating count of emitted tokens
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_token_count <= '0;
        end else if (w_emit && (r_token_count != CNT_MAX)) begin
            r_token_count <= r_token_count + CNT_W'(1);
        end
    end

    // Saturating count of accepted words that differed from EXPECTED
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mismatch_count <= '0;
        end else if (w_word_bad && (r_mismatch_count != CNT_MAX)) begin
            r_mismatch_count <= r_mismatch_count + CNT_W'(1);
        end
    end

    assign token_count    = r_token_count;
    assign mismatch_count = r_mismatch_count;
`else
    assign token_count    = CNT_W'(0);
    assign mismatch_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_handshake_constant_sink.sv
// Directed bench for handshake_constant_sink (stats checks follow the macro).
module tb_handshake_constant_sink;

    localparam int unsigned DW = 36;
    localparam logic [DW-1:0] EXP_WORD = 36'h6DC59362C;

    logic          clk;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic          mismatch;
    logic [15:0]   mismatch_count;
    logic [15:0]   token_count;

    int n_checks;
    int n_pass;
    int tok_seen;

    handshake_constant_sink #(
        .DATA_WIDTH (DW),
        .EXPECTED   (EXP_WORD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ins            (ins),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ctrl_valid     (ctrl_valid),
        .ctrl_ready     (ctrl_ready),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count),
        .token_count    (token_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Count an emit seen just before the edge, then advance to 1 time unit past it
    task automatic tick();
        if (rst && ctrl_valid && ctrl_ready) tok_seen++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        tok_seen   = 0;
        rst        = 1'b0;
        ins        = EXP_WORD;
        ins_valid  = 1'b1;
        ctrl_ready = 1'b0;

        // Reset held for 3 edges with ins_valid high
        repeat (3) tick();
        check("rst_ins_ready",  36'(ins_ready),  36'd1);
        check("rst_ctrl_valid", 36'(ctrl_valid), 36'd0);
        check("rst_mismatch",   36'(mismatch),   36'd0);
        check("rst_tok_cnt",    36'(token_count),    36'd0);
        check("rst_mis_cnt",    36'(mismatch_count), 36'd0);

        // Streaming: 10 matching words with ctrl_ready held high
        rst        = 1'b1;
        ctrl_ready = 1'b1;
        ins_valid  = 1'b1;
        tick();
        check("stream_first_valid", 36'(ctrl_valid), 36'd1);
        check("stream_first_tok",   36'(tok_seen),   36'd0);
        for (int i = 1; i < 10; i++) begin
            tick();
            check("stream_valid", 36'(ctrl_valid), 36'd1);
            check("stream_ready", 36'(ins_ready),  36'd1);
            check("stream_tok",   36'(tok_seen),   36'(i));
        end
        ins_valid = 1'b0;
        tick();
        check("stream_drained",  36'(ctrl_valid), 36'd0);
        check("stream_tokens",   36'(tok_seen),   36'd10);
        check("stream_mismatch", 36'(mismatch),   36'd0);
`ifdef HANDSHAKE_CONSTANT_SINK_STATS_EN
        check("stream_tok_cnt", 36'(token_count),    36'd10);
        check("stream_mis_cnt", 36'(mismatch_count), 36'd0);
`else
        check("stream_tok_cnt_off", 36'(token_count),    36'd0);
        check("stream_mis_cnt_off", 36'(mismatch_count), 36'd0);
`endif

        // Backpressure: two accepts fill the buffer, then ready drops
        tok_seen   = 0;
        ctrl_ready = 1'b0;
        ins_valid  = 1'b1;
        tick();
        check("bp_one_ready", 36'(ins_ready),  36'd1);
        check("bp_one_valid", 36'(ctrl_valid), 36'd1);
        tick();
        check("bp_full_ready", 36'(ins_ready),  36'd0);
        check("bp_full_valid", 36'(ctrl_valid), 36'd1);
        tick();
        check("bp_hold_ready", 36'(ins_ready), 36'd0);
        ctrl_ready = 1'b1;
        ins_valid  = 1'b0;
        tick();
        check("bp_emit1_ready", 36'(ins_ready),  36'd1);
        check("bp_emit1_valid", 36'(ctrl_valid), 36'd1);
        tick();
        check("bp_emit2_valid", 36'(ctrl_valid), 36'd0);
        check("bp_tokens",      36'(tok_seen),   36'd2);

        // Mismatch: bad word still accepted and still yields a token
        tok_seen  = 0;
        ins       = 36'h000000001;
        ins_valid = 1'b1;
        tick();
        check("mis_set",   36'(mismatch),   36'd1);
        check("mis_valid", 36'(ctrl_valid), 36'd1);
        ins = EXP_WORD;
        tick();
        check("mis_sticky", 36'(mismatch), 36'd1);
        ins_valid = 1'b0;
        ins       = 36'h0;
        tick();
        tick();
        check("mis_sticky2", 36'(mismatch), 36'd1);
        check("mis_tokens",  36'(tok_seen), 36'd2);
`ifdef HANDSHAKE_CONSTANT_SINK_STATS_EN
        check("mis_cnt",     36'(mismatch_count), 36'd1);
        check("mis_tok_cnt", 36'(token_count),    36'd14);
`endif

        // Mid-operation reset while FULL discards buffered tokens
        tok_seen   = 0;
        ctrl_ready = 1'b0;
        ins        = EXP_WORD;
        ins_valid  = 1'b1;
        tick();
        tick();
        check("mid_full", 36'(ins_ready), 36'd0);
        rst        = 1'b0;
        ctrl_ready = 1'b1;
        tick();
        check("mid_rst_ready",    36'(ins_ready),  36'd1);
        check("mid_rst_valid",    36'(ctrl_valid), 36'd0);
        check("mid_rst_mismatch", 36'(mismatch),   36'd0);
        check("mid_rst_tok_cnt",  36'(token_count),    36'd0);
        check("mid_rst_mis_cnt",  36'(mismatch_count), 36'd0);
        rst       = 1'b1;
        ins_valid = 1'b0;
        tick();
        tick();
        check("mid_no_stale_valid", 36'(ctrl_valid), 36'd0);
        check("mid_no_stale_tok",   36'(tok_seen),   36'd0);

`ifdef HANDSHAKE_CONSTANT_SINK_STATS_EN
        // Saturation: 65540 emits pin token_count at 16'hFFFF
        ins_valid  = 1'b1;
        ctrl_ready = 1'b1;
        tick();
        for (int i = 0; i < 65540; i++) tick();
        check("sat_tok_cnt", 36'(token_count),    36'hFFFF);
        check("sat_mis_cnt", 36'(mismatch_count), 36'd0);
        ins_valid = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
